score_recorder: RTL and testbench
=================================

# score_recorder

Captures a live key stream into score memory as (note, duration) records, one write per held note. It runs on the same 1220.70 Hz tick clock as score playback. Durations are therefore in the tick units playback consumes, and a recorded buffer can be replayed directly. It sits between the key source (keyboard scanner or test pattern) and a score RAM write port.

## Interface
- MAX_REC, default 16'hFFFF: record capacity; the pointer never exceeds this value.
- clk  in  1  tick clock, 1220.70 Hz
- grst  in  1  reset, asynchronous, active-high
- arm  in  1  start-recording pulse; sampled on clk
- stop  in  1  stop-recording pulse; sampled on clk
- key_in  in  7  live note number; 0 = rest, recorded like any other note
- we  out  1  write strobe, one cycle per record
- waddr  out  16  record address
- wnote  out  7  record note
- wdur  out  16  record duration in ticks, 1..16'hFFFF
- rec_len  out  16  number of records written since the last arm
- busy  out  1  high in state REC
- full  out  1  capacity reached; sticky until arm or grst

## Operation
- States:
  - IDLE: after reset.
  - REC: recording.
  - DONE: stopped or full.
- IDLE/DONE + arm:
  - next state REC;
  - ptr <= 0; cur_note <= key_in; dur <= 1; full <= 0.
- REC, each clk, evaluated in this order:
  - stop: emit (cur_note, dur) -> DONE.
  - key_in != cur_note, or dur == 16'hFFFF: emit (cur_note, dur); cur_note <= key_in; dur <= 1.
  - otherwise: dur <= dur + 1.
- Emit means: we <= 1; waddr <= ptr; wnote <= cur_note; wdur <= dur; ptr <= ptr + 1.
- Full: if an emit makes ptr + 1 == MAX_REC, then full <= 1 and the state goes to DONE, even with no stop.
- arm is ignored while in REC.
- stop is ignored in IDLE and DONE.
- Duration saturation: a note held longer than 16'hFFFF ticks is split into consecutive records of the same note. The first record has wdur 16'hFFFF.
- Simultaneous stop and key change: exactly one record is emitted, holding the old note and its count. The new key is discarded.
- rec_len = ptr. busy = (state == REC).
- Width rules:
  - dur and ptr are 16-bit unsigned.
  - dur never wraps; the saturation rule above fires first.
  - ptr never passes MAX_REC.

## Timing
- All outputs are registered.
- Reset values: we=0, waddr=0, wnote=0, wdur=0, rec_len=0, busy=0, full=0, state IDLE.
- grst mid-record: immediate return to reset values. No partial record is written.
- Event latency: a key change sampled at edge N produces we=1 in the cycle after edge N. The write fields are valid together with we.
- we is high for exactly one cycle per record. Two consecutive changes give we high on two consecutive cycles.
- The first tick after arm is counted: arm at edge N, key held, change at edge N+k gives wdur = k.
- busy rises the cycle after arm. It falls in the same cycle the final we is asserted.
- rec_len updates in the same cycle as we.

## Structure
- Shared package (with the score player):
  - NOTE_W = 7, DUR_W = 16, ADDR_W = 16;
  - DUR_MAX = 16'hFFFF;
  - state enum {IDLE, REC, DONE};
  - record struct {note, dur}.
- No sub-module: one FSM, one duration counter and one pointer register in a single module.

## Test plan
- Reset: assert grst mid-REC -> all outputs zero and state IDLE asynchronously; no we pulse after release.
- Basic capture, with no stop until afterwards:
  - stimulus: arm with key_in=60; hold 10 ticks; key_in=62 for 5 ticks; key_in=0 for 3 ticks; stop.
  - required: three we pulses: (addr 0, 60, 10), (addr 1, 62, 5), (addr 2, 0, 3); rec_len=3; busy=0.
- Saturation: hold key_in=45 for 70000 ticks, then stop -> records (0, 45, 65535) and (1, 45, 4465).
- Full: MAX_REC=4; toggle key_in every tick -> exactly 4 records at addresses 0..3; full=1; state DONE; later key changes produce no we.
- Simultaneous stop and key change: key_in 50 -> 51 on the same edge as stop after 7 ticks -> one record (50, 7); no record for 51.
- Re-arm from DONE: arm again -> rec_len=0, full=0, first new record written at address 0; arm pulses while in REC have no effect.

Source files
------------

// File: rtl/score_recorder_pkg.sv
// Shared score types: record widths, duration ceiling, recorder states and record payload.
package score_recorder_pkg;

  localparam int unsigned NOTE_W = 7;
  localparam int unsigned DUR_W  = 16;
  localparam int unsigned ADDR_W = 16;

  localparam logic [DUR_W-1:0] DUR_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    DONE = 2'd2
  } rec_state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } score_rec_t;

endpackage

// File: rtl/score_recorder.sv
// Records a live key stream as (note, duration) records into score RAM,
// one write per held note, durations counted in playback ticks.
module score_recorder
  import score_recorder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MAX_REC = 16'hFFFF
) (
  input  logic              clk,
  input  logic              grst,
  input  logic              arm,
  input  logic              stop,
  input  logic [NOTE_W-1:0] key_in,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [NOTE_W-1:0] wnote,
  output logic [DUR_W-1:0]  wdur,
  output logic [ADDR_W-1:0] rec_len,
  output logic              busy,
  output logic              full
);

  rec_state_e        state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_d, waddr_d;
  logic [ADDR_W-1:0] ptr_inc_c;
  logic [NOTE_W-1:0] cur_note, cur_note_d;
  logic [DUR_W-1:0]  dur, dur_d;
  score_rec_t        wrec, wrec_d;
  logic              emit_c, last_c, we_d, full_d;

  assign ptr_inc_c = ptr + ADDR_W'(1);
  assign last_c    = (ptr_inc_c == MAX_REC);

  // State register
  always_ff @(posedge clk or posedge grst) begin
    if (grst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state; stop outranks a key change, and the capacity-filling emit also ends recording
  always_comb begin
    state_next = state;
    emit_c     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arm) state_next = REC;
      end
      REC: begin
        if (stop) begin
          emit_c     = 1'b1;
          state_next = DONE;
        end else if ((key_in != cur_note) || (dur == DUR_MAX)) begin
          emit_c = 1'b1;
        end
        if (emit_c && last_c) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ptr_d      = ptr;
    cur_note_d = cur_note;
    dur_d      = dur;
    full_d     = full;
    we_d       = 1'b0;
    waddr_d    = waddr;
    wrec_d     = wrec;
    if (state != REC) begin
      if (arm) begin
        ptr_d      = '0;
        cur_note_d = key_in;
        dur_d      = DUR_W'(1);
        full_d     = 1'b0;
      end
    end else if (emit_c) begin
      we_d       = 1'b1;
      waddr_d    = ptr;
      wrec_d     = '{note: cur_note, dur: dur};
      ptr_d      = ptr_inc_c;
      cur_note_d = key_in;
      dur_d      = DUR_W'(1);
      if (last_c) full_d = 1'b1;
    end else begin
      dur_d = dur + DUR_W'(1);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      ptr      <= '0;
      cur_note <= '0;
      dur      <= '0;
      full     <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wrec     <= '0;
      busy     <= 1'b0;
    end else begin
      ptr      <= ptr_d;
      cur_note <= cur_note_d;
      dur      <= dur_d;
      full     <= full_d;
      we       <= we_d;
      waddr    <= waddr_d;
      wrec     <= wrec_d;
      busy     <= (state_next == REC);
    end
  end

  assign wnote   = wrec.note;
  assign wdur    = wrec.dur;
  assign rec_len = ptr;

endmodule

// File: tb/tb_score_recorder.sv
// Scoreboard bench for score_recorder: default-capacity instance plus a MAX_REC=4 instance.
module tb_score_recorder;

  typedef struct {
    logic [15:0] addr;
    logic [6:0]  note;
    logic [15:0] dur;
  } exp_t;

  logic        clk = 1'b0;
  logic        grst;
  logic        arm, stop, arm2, stop2;
  logic [6:0]  key_in, key2;
  logic        we, busy, full, we2, busy2, full2;
  logic [15:0] waddr, wdur, rec_len, waddr2, wdur2, rec_len2;
  logic [6:0]  wnote, wnote2;

  exp_t q1[$];
  exp_t q2[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  score_recorder dut (
    .clk(clk), .grst(grst), .arm(arm), .stop(stop), .key_in(key_in),
    .we(we), .waddr(waddr), .wnote(wnote), .wdur(wdur),
    .rec_len(rec_len), .busy(busy), .full(full)
  );

  score_recorder #(.MAX_REC(16'd4)) dut4 (
    .clk(clk), .grst(grst), .arm(arm2), .stop(stop2), .key_in(key2),
    .we(we2), .waddr(waddr2), .wnote(wnote2), .wdur(wdur2),
    .rec_len(rec_len2), .busy(busy2), .full(full2)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  // Monitors: every write strobe pops one expected record
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_we: got addr=%0d note=%0d dur=%0d expected no write", waddr, wnote, wdur);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("waddr", 32'(waddr), 32'(e.addr));
        chk("wnote", 32'(wnote), 32'(e.note));
        chk("wdur", 32'(wdur), 32'(e.dur));
        chk("rec_len_at_we", 32'(rec_len), 32'(e.addr) + 1);
      end
    end
  end

  always @(negedge clk) begin
    if (we2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_we4: got addr=%0d note=%0d dur=%0d expected no write", waddr2, wnote2, wdur2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("waddr4", 32'(waddr2), 32'(e.addr));
        chk("wnote4", 32'(wnote2), 32'(e.note));
        chk("wdur4", 32'(wdur2), 32'(e.dur));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(int k);
    repeat (k - 1) step();
  endtask

  task automatic arm_with(logic [6:0] n);
    arm = 1'b1;
    key_in = n;
    step();
    arm = 1'b0;
  endtask

  task automatic change(logic [6:0] n);
    key_in = n;
    step();
  endtask

  task automatic stop_now();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic push1(int a, int n, int d);
    q1.push_back('{addr: 16'(a), note: 7'(n), dur: 16'(d)});
  endtask

  task automatic push2(int a, int n, int d);
    q2.push_back('{addr: 16'(a), note: 7'(n), dur: 16'(d)});
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (q1.size() != 0 || q2.size() != 0); i++) step();
    step();
    chk("drain_q1", 32'(q1.size()), 0);
    chk("drain_q2", 32'(q2.size()), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    grst = 1'b1;
    arm = 1'b0; stop = 1'b0; key_in = 7'd0;
    arm2 = 1'b0; stop2 = 1'b0; key2 = 7'd0;
    #12;
    chk("rst_we", 32'(we), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wnote", 32'(wnote), 0);
    chk("rst_wdur", 32'(wdur), 0);
    chk("rst_rec_len", 32'(rec_len), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(full), 0);
    @(negedge clk);
    grst = 1'b0;
    step();

    // Stop ignored while idle
    stop_now();
    chk("idle_stop_busy", 32'(busy), 0);

    // Basic capture
    arm_with(7'd60);
    chk("arm_busy", 32'(busy), 1);
    chk("arm_rec_len", 32'(rec_len), 0);
    hold(10);
    push1(0, 60, 10);
    change(7'd62);
    hold(5);
    push1(1, 62, 5);
    change(7'd0);
    hold(3);
    push1(2, 0, 3);
    stop_now();
    chk("stop_we", 32'(we), 1);
    chk("stop_busy", 32'(busy), 0);
    drain();
    chk("basic_rec_len", 32'(rec_len), 3);
    chk("basic_busy", 32'(busy), 0);
    chk("basic_full", 32'(full), 0);

    // Duration saturation
    arm_with(7'd45);
    push1(0, 45, 65535);
    push1(1, 45, 4465);
    repeat (69999) step();
    chk("sat_busy", 32'(busy), 1);
    stop_now();
    drain();
    chk("sat_rec_len", 32'(rec_len), 2);

    // Stop and key change on the same edge
    arm_with(7'd50);
    hold(7);
    push1(0, 50, 7);
    key_in = 7'd51;
    stop = 1'b1;
    step();
    stop = 1'b0;
    change(7'd52);
    change(7'd53);
    stop_now();
    drain();
    chk("simul_rec_len", 32'(rec_len), 1);
    chk("simul_busy", 32'(busy), 0);

    // Re-arm from DONE; arm pulses inside REC are ignored
    arm_with(7'd20);
    chk("rearm_rec_len", 32'(rec_len), 0);
    chk("rearm_busy", 32'(busy), 1);
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (2) step();
    push1(0, 20, 4);
    change(7'd21);
    push1(1, 21, 1);
    stop_now();
    drain();
    chk("rearm_rec_len_end", 32'(rec_len), 2);

    // Capacity: MAX_REC=4, key toggling every tick
    arm2 = 1'b1;
    key2 = 7'd1;
    step();
    arm2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push2(i, (i % 2 == 0) ? 1 : 2, 1);
      key2 = (i % 2 == 0) ? 7'd2 : 7'd1;
      step();
    end
    chk("full_flag", 32'(full2), 1);
    chk("full_busy", 32'(busy2), 0);
    chk("full_rec_len", 32'(rec_len2), 4);
    for (int i = 0; i < 4; i++) begin
      key2 = (i % 2 == 0) ? 7'd3 : 7'd4;
      step();
    end
    stop2 = 1'b1;
    step();
    stop2 = 1'b0;
    drain();
    chk("full_sticky", 32'(full2), 1);

    // Re-arm clears full
    arm2 = 1'b1;
    key2 = 7'd5;
    step();
    arm2 = 1'b0;
    chk("rearm4_full", 32'(full2), 0);
    chk("rearm4_rec_len", 32'(rec_len2), 0);
    push2(0, 5, 1);
    key2 = 7'd6;
    step();
    push2(1, 6, 1);
    stop2 = 1'b1;
    step();
    stop2 = 1'b0;
    drain();

    // Asynchronous reset in the middle of recording
    arm_with(7'd30);
    hold(2);
    change(7'd31);
    chk("pre_reset_we", 32'(we), 1);
    #2;
    grst = 1'b1;
    #1;
    chk("async_we", 32'(we), 0);
    chk("async_waddr", 32'(waddr), 0);
    chk("async_wnote", 32'(wnote), 0);
    chk("async_wdur", 32'(wdur), 0);
    chk("async_rec_len", 32'(rec_len), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_full", 32'(full), 0);
    change(7'd32);
    #2;
    grst = 1'b0;
    change(7'd33);
    change(7'd34);
    stop_now();
    drain();
    chk("post_reset_busy", 32'(busy), 0);
    chk("post_reset_rec_len", 32'(rec_len), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
